// File: rtl/client_read_arb.sv
// rtl/client_read_arb.sv - 16-client SRAM read arbiter, priority client with streak cap plus round-robin
module client_read_arb (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       client_read_req,
   input  logic [15:0][18:0] client_read_addr,
   input  logic [4:0]        client_priority,
   output logic [15:0]       client_read_ack,
   output logic              arb_valid,
   output logic [3:0]        arb_client,
   output logic [18:0]       arb_addr,
   input  logic              arb_ready
);

   logic [3:0]  rr_ptr;
   logic [2:0]  streak;
   logic        slot_free;
   logic        sel;
   logic        prio_hit;
   logic        rr_found;
   logic [3:0]  prio_idx;
   logic [3:0]  rr_win;
   logic [3:0]  win;
   logic [3:0]  idx;
   logic [15:0] scan_mask;

   always_comb begin
      prio_idx  = client_priority[3:0];
      slot_free = !arb_valid | arb_ready;
      sel       = slot_free & !rst & (|client_read_req);
      prio_hit  = client_priority[4] & client_read_req[prio_idx] & (streak < 3'd4);

      // Once the priority client has used up its streak, it only wins the scan when alone.
      scan_mask = client_read_req;
      if (streak == 3'd4 && client_read_req != (16'd1 << prio_idx))
         scan_mask[prio_idx] = 1'b0;

      rr_win   = '0;
      rr_found = 1'b0;
      idx      = '0;
      for (int i = 0; i < 16; i++) begin
         idx = rr_ptr + 4'(i);
         if (!rr_found && scan_mask[idx]) begin
            rr_win   = idx;
            rr_found = 1'b1;
         end
      end

      win = prio_hit ? prio_idx : rr_win;

      client_read_ack = '0;
      if (sel)
         client_read_ack[win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         arb_valid  <= 1'b0;
         arb_client <= '0;
         arb_addr   <= '0;
         rr_ptr     <= '0;
         streak     <= '0;
      end else if (sel) begin
         arb_valid  <= 1'b1;
         arb_client <= win;
         arb_addr   <= client_read_addr[win];
         if (prio_hit) begin
            streak <= streak + 3'd1;
         end else begin
            rr_ptr <= win + 4'd1;
            streak <= '0;
         end
      end else if (arb_valid && arb_ready) begin
         arb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_client_read_arb.sv
// tb/tb_client_read_arb.sv - vector table, corner sequences and random run against a queue-based model
module tb_client_read_arb;

   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       req;
   logic [15:0][18:0] addr;
   logic [4:0]        prio;
   logic [15:0]       ack;
   logic              arb_valid;
   logic [3:0]        arb_client;
   logic [18:0]       arb_addr;
   logic              ready;

   int total = 0;
   int bad   = 0;

   int          m_rr, m_streak, m_client;
   bit          m_valid;
   logic [18:0] m_addr;

   typedef struct {
      logic [15:0] req;
      logic [4:0]  prio;
      logic        ready;
      logic [15:0] ack;
      logic        valid;
      logic [3:0]  client;
   } vec_t;
   vec_t vec [15];

   client_read_arb dut (
      .clk              (clk),
      .rst              (rst),
      .client_read_req  (req),
      .client_read_addr (addr),
      .client_priority  (prio),
      .client_read_ack  (ack),
      .arb_valid        (arb_valid),
      .arb_client       (arb_client),
      .arb_addr         (arb_addr),
      .arb_ready        (ready)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] addr_of(input int i);
      if (i == 5) return 19'h12345;
      return 19'(i * 32'h1357 + 32'h2468);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Winner from the rules: priority if eligible, else first requester going up from rr_ptr.
   function automatic void model_pick(output bit found, output bit is_prio, output int w);
      int q[$];
      found = 0; is_prio = 0; w = 0;
      if (rst || !(!m_valid || ready) || req == 16'd0) return;
      found = 1;
      if (prio[4] && req[prio[3:0]] && m_streak < 4) begin
         is_prio = 1;
         w = int'(prio[3:0]);
         return;
      end
      for (int k = 0; k < 16; k++)
         if (req[(m_rr + k) % 16]) q.push_back((m_rr + k) % 16);
      if (m_streak == 4 && q.size() > 1)
         for (int j = 0; j < q.size(); j++)
            if (q[j] == int'(prio[3:0])) begin
               q.delete(j);
               break;
            end
      w = q[0];
   endfunction

   task automatic run_cycle(output logic [15:0] ack_seen);
      bit          f, p;
      int          w;
      logic [15:0] eack;
      #4;
      model_pick(f, p, w);
      eack = f ? (16'd1 << w) : 16'd0;
      ack_seen = ack;
      chk("model_ack", 32'(ack), 32'(eack));
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_client = 0; m_addr = '0; m_rr = 0; m_streak = 0;
      end else if (f) begin
         m_valid = 1; m_client = w; m_addr = addr_of(w);
         if (p) m_streak++;
         else begin
            m_rr = (w + 1) % 16;
            m_streak = 0;
         end
      end else if (m_valid && ready) begin
         m_valid = 0;
      end
      #1;
      chk("model_valid", 32'(arb_valid), 32'(m_valid));
      chk("model_client", 32'(arb_client), 32'(m_client));
      chk("model_addr", 32'(arb_addr), 32'(m_addr));
   endtask

   initial begin
      logic [15:0] a;
      int          exp_streak [5];

      for (int i = 0; i < 16; i++) addr[i] = addr_of(i);
      vec[0]  = '{16'h0020, 5'h00, 1'b1, 16'h0020, 1'b1, 4'd5};
      vec[1]  = '{16'h0000, 5'h00, 1'b1, 16'h0000, 1'b0, 4'd5};
      vec[2]  = '{16'h0088, 5'h13, 1'b1, 16'h0008, 1'b1, 4'd3};
      vec[3]  = '{16'h0088, 5'h13, 1'b1, 16'h0008, 1'b1, 4'd3};
      vec[4]  = '{16'h0088, 5'h13, 1'b1, 16'h0008, 1'b1, 4'd3};
      vec[5]  = '{16'h0088, 5'h13, 1'b1, 16'h0008, 1'b1, 4'd3};
      vec[6]  = '{16'h0088, 5'h13, 1'b1, 16'h0080, 1'b1, 4'd7};
      vec[7]  = '{16'h0088, 5'h13, 1'b1, 16'h0008, 1'b1, 4'd3};
      vec[8]  = '{16'h0088, 5'h13, 1'b1, 16'h0008, 1'b1, 4'd3};
      vec[9]  = '{16'h0088, 5'h13, 1'b1, 16'h0008, 1'b1, 4'd3};
      vec[10] = '{16'h0088, 5'h13, 1'b1, 16'h0008, 1'b1, 4'd3};
      vec[11] = '{16'h0088, 5'h13, 1'b1, 16'h0080, 1'b1, 4'd7};
      vec[12] = '{16'h0000, 5'h00, 1'b0, 16'h0000, 1'b1, 4'd7};
      vec[13] = '{16'h0002, 5'h00, 1'b0, 16'h0000, 1'b1, 4'd7};
      vec[14] = '{16'h0002, 5'h00, 1'b1, 16'h0002, 1'b1, 4'd1};
      exp_streak = '{1, 2, 3, 4, 0};

      rst = 1'b1; req = '0; prio = '0; ready = 1'b1;
      m_valid = 0; m_client = 0; m_addr = '0; m_rr = 0; m_streak = 0;
      @(posedge clk); #1;
      run_cycle(a);
      chk("reset_valid", 32'(arb_valid), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         req = vec[i].req; prio = vec[i].prio; ready = vec[i].ready;
         run_cycle(a);
         chk($sformatf("tbl%0d_ack", i), 32'(a), 32'(vec[i].ack));
         chk($sformatf("tbl%0d_valid", i), 32'(arb_valid), 32'(vec[i].valid));
         chk($sformatf("tbl%0d_client", i), 32'(arb_client), 32'(vec[i].client));
         if (i == 0) chk("tbl0_addr", 32'(arb_addr), 32'h12345);
      end

      // Backpressure: hold client 9 for 10 cycles while everyone requests.
      req = 16'h0200; prio = 5'h00; ready = 1'b1;
      run_cycle(a);
      chk("bp_grant9", 32'(a), 32'h0200);
      req = 16'hffff; ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         run_cycle(a);
         chk("bp_ack0", 32'(a), 32'd0);
         chk("bp_valid", 32'(arb_valid), 32'd1);
         chk("bp_client", 32'(arb_client), 32'd9);
         chk("bp_addr", 32'(arb_addr), 32'(addr_of(9)));
      end
      ready = 1'b1;
      run_cycle(a);
      chk("bp_release", 32'(a), 32'h0400);

      // Reset while a request is held off by backpressure.
      ready = 1'b0;
      run_cycle(a);
      chk("hold_client", 32'(arb_client), 32'd10);
      rst = 1'b1;
      run_cycle(a);
      chk("rst_ack", 32'(a), 32'd0);
      chk("rst_valid", 32'(arb_valid), 32'd0);
      chk("rst_client", 32'(arb_client), 32'd0);
      chk("rst_addr", 32'(arb_addr), 32'd0);
      rst = 1'b0; req = '0; ready = 1'b1;
      run_cycle(a);
      chk("rst_no_replay", 32'(arb_valid), 32'd0);

      // Plain round-robin over all 16 clients from rr_ptr=0.
      req = 16'hffff; prio = 5'h00;
      for (int k = 0; k < 17; k++) begin
         run_cycle(a);
         chk($sformatf("rr_%0d", k), 32'(a), 32'(16'd1 << (k % 16)));
      end

      // Lone priority client: granted every cycle, streak wraps through 4.
      req = 16'h0008; prio = 5'h13;
      for (int k = 0; k < 5; k++) begin
         run_cycle(a);
         chk($sformatf("lone_ack%0d", k), 32'(a), 32'h0008);
         chk($sformatf("lone_streak%0d", k), 32'(dut.streak), 32'(exp_streak[k]));
      end

      for (int k = 0; k < 400; k++) begin
         rst   = ($urandom_range(0, 49) == 0);
         req   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
         prio  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : {1'b1, 4'($urandom_range(0, 3))};
         ready = ($urandom_range(0, 9) < 7);
         run_cycle(a);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
